// File: rtl/fracbrg_pkg.sv
// fracbrg_pkg: shared divisor arithmetic and configuration checks for the fractional baud rate generator.
//   brg_div    - rounded accumulator increment for a baud rate
//   brg_cnt_w  - width of the oversample counter
//   brg_cfg_ok - parameter legality (oversample, resolution, divisor range)
package fracbrg_pkg;

    function automatic longint brg_div(longint clk_hz, longint baud, longint os, longint res);
        longint one;
        one = 1;
        return (baud * os * (one << res) * 2 + clk_hz) / (2 * clk_hz);
    endfunction

    function automatic int brg_cnt_w(int os);
        return $clog2(os);
    endfunction

    function automatic bit brg_cfg_ok(longint clk_hz, longint baud, longint os, longint res);
        longint one;
        longint d;
        one = 1;
        d = brg_div(clk_hz, baud, os, res);
        return (os >= 4) && ((os & (os - 1)) == 0) && (res >= 8) && (res <= 24) &&
               (d != 0) && (d < (one << res));
    endfunction

endpackage

// File: rtl/fracbrg_acc.sv
// fracbrg_acc: phase accumulator with enable, clear and a registered carry tick.
//   clk_i, rst_i - clock, synchronous active-high reset
//   en_i         - add div_i to the phase this clock
//   clr_i        - clear the phase and the tick
//   div_i        - phase increment (0 freezes the phase)
//   carry_o      - combinational overflow of this clock's addition
//   stb_o        - carry_o registered: the oversample tick
module fracbrg_acc #(
    parameter int RESOLUTION = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  clr_i,
    input  logic [RESOLUTION-1:0] div_i,
    output logic                  carry_o,
    output logic                  stb_o
);

    logic [RESOLUTION-1:0] r_acc;
    logic                  r_stb;
    logic [RESOLUTION:0]   w_sum;

    assign w_sum   = {1'b0, r_acc} + {1'b0, div_i};
    assign carry_o = en_i & ~clr_i & w_sum[RESOLUTION];
    assign stb_o   = r_stb;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_acc <= '0;
            r_stb <= 1'b0;
        end else begin
            if (en_i) r_acc <= w_sum[RESOLUTION-1:0];
            r_stb <= carry_o;
        end
    end

endmodule

// File: rtl/fracbrg_prog.sv
// fracbrg_prog: runtime-programmable fractional baud rate generator with bit-aligned divisor updates.
//   clk_i, rst_i - clock, synchronous active-high reset
//   en_i         - count enable (phase and counter hold when low)
//   sync_i       - re-phase: clears phase and oversample counter
//   div_i/div_wr_i - divisor write; applied on the next bit boundary
//   div_o        - active divisor, div_pend_o - a write awaits application
//   os_stb_o, mid_stb_o, bit_stb_o - registered one-clock strobes
module fracbrg_prog
    import fracbrg_pkg::*;
#(
    parameter int CLK_HZ     = 24000000,
    parameter int BAUDRATE   = 38400,
    parameter int OVERSAMPLE = 16,
    parameter int RESOLUTION = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  sync_i,
    input  logic [RESOLUTION-1:0] div_i,
    input  logic                  div_wr_i,
    output logic [RESOLUTION-1:0] div_o,
    output logic                  div_pend_o,
    output logic                  os_stb_o,
    output logic                  mid_stb_o,
    output logic                  bit_stb_o
);

    localparam longint                DEF     = brg_div(CLK_HZ, BAUDRATE, OVERSAMPLE, RESOLUTION);
    localparam logic [RESOLUTION-1:0] DEF_DIV = RESOLUTION'(DEF);
    localparam int                    CW      = brg_cnt_w(OVERSAMPLE);
    localparam logic [CW-1:0]         LAST    = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0]         MID     = CW'(OVERSAMPLE / 2 - 1);

    if (!brg_cfg_ok(CLK_HZ, BAUDRATE, OVERSAMPLE, RESOLUTION)) begin : g_cfg_err
        $error("fracbrg_prog: illegal OVERSAMPLE/RESOLUTION or default divisor out of range");
    end

    logic [CW-1:0]         r_os_cnt;
    logic                  r_mid;
    logic                  r_bit;
    logic                  r_pend;
    logic [RESOLUTION-1:0] r_div_act;
    logic [RESOLUTION-1:0] r_div_next;
    logic                  w_carry;
    logic                  w_os;
    logic                  w_bit;
    logic                  w_apply;
    logic                  w_load;

    fracbrg_acc #(.RESOLUTION(RESOLUTION)) u_acc (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (en_i),
        .clr_i   (sync_i),
        .div_i   (r_div_act),
        .carry_o (w_carry),
        .stb_o   (w_os)
    );

    // A shadow divisor may only take effect where the rate change cannot tear a bit:
    // on a boundary, while idle or stopped, or when the phase is being reset anyway.
    assign w_bit   = w_carry & (r_os_cnt == LAST);
    assign w_apply = sync_i | ~en_i | (r_div_act == '0) | w_bit;
    assign w_load  = w_apply & (r_pend | div_wr_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_os_cnt   <= '0;
            r_mid      <= 1'b0;
            r_bit      <= 1'b0;
            r_pend     <= 1'b0;
            r_div_act  <= DEF_DIV;
            r_div_next <= DEF_DIV;
        end else begin
            r_os_cnt <= sync_i ? '0 : r_os_cnt + CW'(w_carry);
            r_mid    <= w_carry & (r_os_cnt == MID);
            r_bit    <= w_bit;
            if (div_wr_i) r_div_next <= div_i;
            if (w_load) r_div_act <= div_wr_i ? div_i : r_div_next;
            r_pend <= ~w_apply & (r_pend | div_wr_i);
        end
    end

    assign div_o      = r_div_act;
    assign div_pend_o = r_pend;
    assign os_stb_o   = w_os;
    assign mid_stb_o  = r_mid;
    assign bit_stb_o  = r_bit;

endmodule

// File: tb/tb_fracbrg_prog.sv
// tb_fracbrg_prog: randomized and directed checks of fracbrg_prog against a phase/tick-count reference model.
module tb_fracbrg_prog;

    localparam int M  = 256;
    localparam int OS = 4;
    localparam int SDEF = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, en = 1'b0, sync = 1'b0, wr = 1'b0;
    logic [7:0] div = '0;
    logic [7:0] div_o;
    logic       pend, os, mid, b_stb;

    fracbrg_prog #(.RESOLUTION(8), .OVERSAMPLE(4)) u_small (
        .clk_i(clk), .rst_i(rst), .en_i(en), .sync_i(sync), .div_i(div), .div_wr_i(wr),
        .div_o(div_o), .div_pend_o(pend), .os_stb_o(os), .mid_stb_o(mid), .bit_stb_o(b_stb)
    );

    logic        d_rst = 1'b1, d_en = 1'b0;
    logic [15:0] d_div_o;
    logic        d_pend, d_os, d_mid, d_bit;

    fracbrg_prog u_def (
        .clk_i(clk), .rst_i(d_rst), .en_i(d_en), .sync_i(1'b0), .div_i(16'd0), .div_wr_i(1'b0),
        .div_o(d_div_o), .div_pend_o(d_pend), .os_stb_o(d_os), .mid_stb_o(d_mid), .bit_stb_o(d_bit)
    );

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: the phase is a number in [0,M); every enabled clock adds the divisor,
    // each wrap past M is one tick, and ticks since the last re-phase locate the bit position.
    int m_acc, m_ticks, m_act, m_next;
    bit m_pend, e_os, e_mid, e_bit;

    task automatic cyc(input logic r, input logic e, input logic s, input logic w, input logic [7:0] d);
        bit tick, bnd, app;
        @(negedge clk);
        rst = r; en = e; sync = s; wr = w; div = d;
        @(posedge clk);
        if (r) begin
            m_acc = 0; m_ticks = 0; m_act = SDEF; m_next = SDEF; m_pend = 0;
            e_os = 0; e_mid = 0; e_bit = 0;
        end else begin
            tick = 0;
            if (s) begin
                m_acc = 0; m_ticks = 0;
            end else if (e) begin
                tick = (m_acc + m_act) >= M;
                m_acc = (m_acc + m_act) % M;
            end
            bnd   = tick && (m_ticks % OS == OS - 1);
            e_os  = tick;
            e_mid = tick && (m_ticks % OS == OS / 2 - 1);
            e_bit = bnd;
            if (tick) m_ticks++;
            app = s || !e || m_act == 0 || bnd;
            if (w) m_next = d;
            if (app && (m_pend || w)) m_act = m_next;
            m_pend = !app && (m_pend || w);
        end
        #1;
        chk("os_stb", os, e_os);
        chk("mid_stb", mid, e_mid);
        chk("bit_stb", b_stb, e_bit);
        chk("div_o", div_o, m_act);
        chk("div_pend", pend, m_pend);
    endtask

    initial begin
        int fo, fm, fb, n, k1, k2, cnt, nos, nbit, nmid;
        bit seen;
        // reset state
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 8'd99);
        chk("rst_div", div_o, SDEF);
        chk("rst_pend", pend, 0);
        chk("rst_strobes", {os, mid, b_stb}, 0);
        // exact rate at div 64, written while disabled
        cyc(0, 0, 0, 1, 64);
        chk("wr_idle_div", div_o, 64);
        fo = 0; fm = 0; fb = 0; nos = 0; nbit = 0;
        for (int i = 1; i <= 40; i++) begin
            cyc(0, 1, 0, 0, 0);
            if (os && fo == 0) fo = i;
            if (mid && fm == 0) fm = i;
            if (b_stb && fb == 0) fb = i;
            nos += int'(os); nbit += int'(b_stb);
        end
        chk("first_os", fo, 4);
        chk("first_mid", fm, 8);
        chk("first_bit", fb, 16);
        chk("os_in_40", nos, 10);
        chk("bit_in_40", nbit, 2);
        // deferred update
        n = 0;
        while (!b_stb && n < 100) begin cyc(0, 1, 0, 0, 0); n++; end
        chk("bit_seen", b_stb, 1);
        cyc(0, 1, 0, 1, 128);
        chk("defer_pend", pend, 1);
        chk("defer_div", div_o, 64);
        n = 0;
        do begin cyc(0, 1, 0, 0, 0); n++; end while (!b_stb && n < 100);
        chk("defer_bit_seen", b_stb, 1);
        chk("applied_div", div_o, 128);
        chk("applied_pend", pend, 0);
        k1 = 0; k2 = 0;
        for (int i = 1; i <= 10; i++) begin
            cyc(0, 1, 0, 0, 0);
            if (os && k1 == 0) k1 = i;
            else if (os && k2 == 0) k2 = i;
        end
        chk("fast_first_os", k1, 2);
        chk("fast_period", k2 - k1, 2);
        // sync re-phase mid-bit
        cyc(0, 0, 0, 1, 64);
        cyc(0, 1, 1, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0);
        fb = 0;
        for (int i = 1; i <= 40 && fb == 0; i++) begin
            cyc(0, 1, 0, 0, 0);
            if (b_stb) fb = i;
        end
        chk("sync_bit_after", fb, 16);
        // enable hold keeps phase
        for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0, 0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 0, 0, 0);
            cnt += int'(os) + int'(mid) + int'(b_stb);
        end
        chk("hold_strobes", cnt, 0);
        fo = 0;
        for (int i = 1; i <= 8 && fo == 0; i++) begin
            cyc(0, 1, 0, 0, 0);
            if (os) fo = i;
        end
        chk("resume_os", fo, 2);
        // stop with div 0, then restart
        cyc(0, 1, 0, 1, 0);
        chk("stop_pend", pend, 1);
        n = 0;
        while (pend && n < 100) begin cyc(0, 1, 0, 0, 0); n++; end
        chk("stop_applied", div_o, 0);
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            cyc(0, 1, 0, 0, 0);
            cnt += int'(os) + int'(mid) + int'(b_stb);
        end
        chk("stopped_strobes", cnt, 0);
        cyc(0, 1, 0, 1, 64);
        chk("restart_div", div_o, 64);
        fo = 0;
        for (int i = 1; i <= 8 && fo == 0; i++) begin
            cyc(0, 1, 0, 0, 0);
            if (os) fo = i;
        end
        chk("restart_os", fo, 4);
        // reset with a pending write
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 1, 128);
        chk("mid_pend", pend, 1);
        cyc(1, 1, 0, 0, 0);
        chk("rst2_div", div_o, SDEF);
        chk("rst2_out", {pend, os, mid, b_stb}, 0);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] d;
            case ($urandom_range(0, 4))
                0: d = 8'd0;
                1: d = 8'd64;
                2: d = 8'd255;
                default: d = 8'($urandom_range(1, 255));
            endcase
            cyc($urandom_range(0, 499) == 0, $urandom_range(0, 9) != 0,
                $urandom_range(0, 49) == 0, $urandom_range(0, 39) == 0, d);
        end
        cyc(0, 0, 0, 0, 0);
        // default configuration: one full phase revolution
        d_rst = 1'b1;
        @(posedge clk); #1;
        chk("def_div", d_div_o, 1678);
        chk("def_rst_out", {d_pend, d_os, d_mid, d_bit}, 0);
        @(negedge clk);
        d_rst = 1'b0; d_en = 1'b1;
        nos = 0; nmid = 0; nbit = 0;
        for (int i = 0; i < 65536; i++) begin
            @(posedge clk); #1;
            nos += int'(d_os); nmid += int'(d_mid); nbit += int'(d_bit);
        end
        chk("def_os_count", nos, 1678);
        chk("def_mid_count", nmid, 105);
        chk("def_bit_count", nbit, 104);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
